// File: rtl/watermark_pkg.sv
// Shared constants and types for the pixel result bus transmit path.
package watermark_pkg;

    localparam int Data_Depth = 8;
    localparam int ADDR_W     = 20;
    localparam int SIZE_W     = 10;
    localparam int MLOG_W     = 3;
    localparam int M_W        = 8;
    localparam int CNT_W      = 2 * SIZE_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } stream_st_t;

    function automatic logic [M_W-1:0] m_from_log2(input logic [MLOG_W-1:0] lg);
        return M_W'(1) << lg;
    endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry pixel FIFO; push data is written on the clock edge, head is combinational.
// Push and pop on a full FIFO in the same cycle is legal; a push into a full FIFO without a pop is dropped.
module pix_skid_fifo
    import watermark_pkg::*;
#(
    parameter int W = Data_Depth
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // When full, wr_ptr equals rd_ptr: the head is read before being overwritten.
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/block_pixel_streamer.sv
// Streams an NxN image from RAM in MxM block order; first pixel two cycles after the read issue.
// Reads are throttled so the 2-entry FIFO never overflows; new_pixel/Pixel_Data hold while out_ready is low.
module block_pixel_streamer
    import watermark_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIZE_W-1:0]     image_size,
    input  logic [MLOG_W-1:0]     m_log2,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [Data_Depth-1:0] mem_rdata,
    output logic                  new_pixel,
    output logic [Data_Depth-1:0] Pixel_Data,
    input  logic                  out_ready,
    output logic [M_W-1:0]        M,
    output logic                  Image_Done,
    output logic                  busy,
    output logic                  cfg_err
);

    stream_st_t        state;
    logic [SIZE_W-1:0] n_reg;
    logic [M_W-1:0]    mm1;
    logic [SIZE_W-1:0] nblk_m1;
    logic [CNT_W-1:0]  n_mm1;
    logic [CNT_W-1:0]  nn_m1;
    logic [ADDR_W-1:0] addr;
    logic [M_W-1:0]    col;
    logic [M_W-1:0]    row;
    logic [SIZE_W-1:0] blk;
    logic [SIZE_W-1:0] strip;
    logic              rd_pend;
    logic [CNT_W-1:0]  pix_cnt;

    logic [M_W-1:0]    m_req;
    logic              cfg_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_cnt;
    logic              hs;
    logic              col_end;
    logic              row_end;
    logic              blk_end;
    logic              strip_end;

    assign m_req  = m_from_log2(m_log2);
    assign cfg_ok = (image_size != '0)
                  && (SIZE_W'(m_req) <= image_size)
                  && ((image_size & SIZE_W'(m_req - M_W'(1))) == '0);

    assign new_pixel = ~fifo_empty;
    assign hs        = new_pixel & out_ready;

    // Reserve a FIFO slot for every read in flight, crediting the slot freed by this cycle's pop.
    assign mem_rd   = (state == RUN)
                    && ((3'(fifo_cnt) + 3'(rd_pend)) < (3'd2 + 3'(hs)));
    assign mem_addr = addr;

    assign col_end   = (col == mm1);
    assign row_end   = (row == mm1);
    assign blk_end   = (blk == nblk_m1);
    assign strip_end = (strip == nblk_m1);

    pix_skid_fifo #(.W(Data_Depth)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_pend),
        .push_dat (mem_rdata),
        .pop      (hs),
        .pop_dat  (Pixel_Data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            n_reg      <= '0;
            M          <= '0;
            mm1        <= '0;
            nblk_m1    <= '0;
            n_mm1      <= '0;
            nn_m1      <= '0;
            addr       <= '0;
            col        <= '0;
            row        <= '0;
            blk        <= '0;
            strip      <= '0;
            rd_pend    <= 1'b0;
            pix_cnt    <= '0;
            Image_Done <= 1'b0;
            busy       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            rd_pend    <= mem_rd;
            Image_Done <= 1'b0;
            cfg_err    <= 1'b0;
            if (hs) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            n_reg   <= image_size;
                            M       <= m_req;
                            mm1     <= m_req - M_W'(1);
                            nblk_m1 <= (image_size >> m_log2) - SIZE_W'(1);
                            n_mm1   <= (CNT_W'(image_size) << m_log2) - CNT_W'(image_size);
                            nn_m1   <= CNT_W'(image_size) * CNT_W'(image_size) - CNT_W'(1);
                            addr    <= '0;
                            col     <= '0;
                            row     <= '0;
                            blk     <= '0;
                            strip   <= '0;
                            pix_cnt <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (mem_rd) begin
                        if (!col_end) begin
                            addr <= addr + ADDR_W'(1);
                            col  <= col + M_W'(1);
                        end else if (!row_end) begin
                            addr <= addr + ADDR_W'(n_reg) - ADDR_W'(mm1);
                            col  <= '0;
                            row  <= row + M_W'(1);
                        end else if (!blk_end) begin
                            // Jump back up to the top-left pixel of the next block in this strip.
                            addr <= addr - ADDR_W'(n_mm1) + ADDR_W'(1);
                            col  <= '0;
                            row  <= '0;
                            blk  <= blk + SIZE_W'(1);
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            col   <= '0;
                            row   <= '0;
                            blk   <= '0;
                            strip <= strip + SIZE_W'(1);
                            if (strip_end) begin
                                state <= DRAIN;
                            end
                        end
                    end
                end

                DRAIN: begin
                    if (hs && (pix_cnt == nn_m1)) begin
                        state      <= DONE;
                        Image_Done <= 1'b1;
                        busy       <= 1'b0;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_pixel_streamer.sv
// Directed bench for block_pixel_streamer with a one-cycle-latency RAM model and a bus monitor.
module tb_block_pixel_streamer;
    import watermark_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [SIZE_W-1:0]     image_size;
    logic [MLOG_W-1:0]     m_log2;
    logic                  mem_rd;
    logic [ADDR_W-1:0]     mem_addr;
    logic [Data_Depth-1:0] mem_rdata = '0;
    logic                  new_pixel;
    logic [Data_Depth-1:0] Pixel_Data;
    logic                  out_ready;
    logic [M_W-1:0]        M;
    logic                  Image_Done;
    logic                  busy;
    logic                  cfg_err;

    block_pixel_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .image_size (image_size),
        .m_log2     (m_log2),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .new_pixel  (new_pixel),
        .Pixel_Data (Pixel_Data),
        .out_ready  (out_ready),
        .M          (M),
        .Image_Done (Image_Done),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc;
    int addr_q[$];
    int pix_q[$];
    int hs_cyc_q[$];
    int gold_a[$];
    int gold_p[$];
    int done_cnt, err_cnt, stall_viol, first_rd_cyc, done_cyc;
    logic                  prev_stall = 1'b0;
    logic [Data_Depth-1:0] prev_pix   = '0;
    bit ok;

    function automatic logic [7:0] ramf(input int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ v[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_rdata <= ramf(int'(mem_addr));
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!new_pixel || Pixel_Data !== prev_pix)) stall_viol++;
            if (mem_rd) begin
                if (addr_q.size() == 0) first_rd_cyc = cyc;
                addr_q.push_back(int'(mem_addr));
            end
            if (new_pixel && out_ready) begin
                pix_q.push_back(int'(Pixel_Data));
                hs_cyc_q.push_back(cyc);
            end
            if (Image_Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cfg_err) err_cnt++;
            prev_stall = new_pixel && !out_ready;
            prev_pix   = Pixel_Data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cmp_q(input int a[$], input int b[$]);
        int e;
        e = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] != b[i]) e++;
        return e;
    endfunction

    task automatic clear_mon();
        addr_q.delete();
        pix_q.delete();
        hs_cyc_q.delete();
        done_cnt = 0; err_cnt = 0; stall_viol = 0; first_rd_cyc = -1; done_cyc = -1;
    endtask

    task automatic gold_fill(input int n, input int m);
        gold_a.delete();
        gold_p.delete();
        for (int s = 0; s < n / m; s++)
            for (int b = 0; b < n / m; b++)
                for (int r = 0; r < m; r++)
                    for (int c = 0; c < m; c++) begin
                        gold_a.push_back((s * m + r) * n + b * m + c);
                        gold_p.push_back(int'(ramf((s * m + r) * n + b * m + c)));
                    end
    endtask

    task automatic start_xfer(input int n, input int mlog);
        @(posedge clk); #1;
        image_size = SIZE_W'(n);
        m_log2     = MLOG_W'(mlog);
        start      = 1'b1;
        start_cyc  = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: always ready, 1: toggle every cycle, 2: random
    task automatic wait_done(input int mode, input int budget, output bit done_ok);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
        done_ok = (done_cnt > 0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; image_size = '0; m_log2 = '0; out_ready = 1'b1;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_new_pixel", 64'(new_pixel), 64'd0);
        check("rst_pixel_data", 64'(Pixel_Data), 64'd0);
        check("rst_M", 64'(M), 64'd0);
        check("rst_image_done", 64'(Image_Done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        rst = 1'b1;

        // N=4, M=2, always ready
        clear_mon();
        start_xfer(4, 1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_M", 64'(M), 64'd2);
        wait_done(0, 200, ok);
        check("t1_done_seen", 64'(ok), 64'd1);
        gold_a = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        gold_p.delete();
        foreach (gold_a[i]) gold_p.push_back(int'(ramf(gold_a[i])));
        check("t1_addr_seq", 64'(cmp_q(addr_q, gold_a)), 64'd0);
        check("t1_pix_seq", 64'(cmp_q(pix_q, gold_p)), 64'd0);
        check("t1_first_rd_lat", 64'(first_rd_cyc - start_cyc), 64'd1);
        check("t1_hs_count", 64'(hs_cyc_q.size()), 64'd16);
        if (hs_cyc_q.size() == 16) begin
            check("t1_first_pix_lat", 64'(hs_cyc_q[0] - start_cyc), 64'd3);
            check("t1_back_to_back", 64'(hs_cyc_q[15] - hs_cyc_q[0]), 64'd15);
            check("t1_done_lat", 64'(done_cyc - hs_cyc_q[15]), 64'd1);
        end
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_busy_after", 64'(busy), 64'd0);

        // N=4, M=4, out_ready toggling
        clear_mon();
        start_xfer(4, 2);
        wait_done(1, 400, ok);
        check("t2_done_seen", 64'(ok), 64'd1);
        gold_p.delete();
        for (int i = 0; i < 16; i++) gold_p.push_back(int'(ramf(i)));
        check("t2_pix_seq", 64'(cmp_q(pix_q, gold_p)), 64'd0);
        check("t2_stall_hold", 64'(stall_viol), 64'd0);
        check("t2_done_cnt", 64'(done_cnt), 64'd1);

        // Rejected configurations
        clear_mon();
        start_xfer(6, 2);
        check("t3_cfg_err", 64'(cfg_err), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("t3_err_cnt", 64'(err_cnt), 64'd1);
        check("t3_no_rd", 64'(addr_q.size()), 64'd0);
        check("t3_no_pix", 64'(pix_q.size()), 64'd0);
        clear_mon();
        start_xfer(0, 0);
        check("t3b_busy", 64'(busy), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("t3b_err_cnt", 64'(err_cnt), 64'd1);
        check("t3b_no_rd", 64'(addr_q.size()), 64'd0);
        check("t3b_no_pix", 64'(pix_q.size()), 64'd0);

        // N=8, M=2: asynchronous reset mid-transfer, then a clean rerun
        clear_mon();
        start_xfer(8, 1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (pix_q.size() >= 10) break;
        end
        check("t4_hs_before_rst", 64'(pix_q.size()), 64'd10);
        rst = 1'b0;
        #1;
        check("t4_rst_mem_rd", 64'(mem_rd), 64'd0);
        check("t4_rst_new_pixel", 64'(new_pixel), 64'd0);
        check("t4_rst_pixel_data", 64'(Pixel_Data), 64'd0);
        check("t4_rst_M", 64'(M), 64'd0);
        check("t4_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_mon();
        start_xfer(8, 1);
        wait_done(0, 500, ok);
        check("t4_done_seen", 64'(ok), 64'd1);
        gold_fill(8, 2);
        check("t4_addr_seq", 64'(cmp_q(addr_q, gold_a)), 64'd0);
        check("t4_pix_seq", 64'(cmp_q(pix_q, gold_p)), 64'd0);
        check("t4_done_cnt", 64'(done_cnt), 64'd1);

        // N=64, M=8, random out_ready
        clear_mon();
        start_xfer(64, 3);
        wait_done(2, 20000, ok);
        check("t5_done_seen", 64'(ok), 64'd1);
        gold_fill(64, 8);
        check("t5_hs_count", 64'(pix_q.size()), 64'd4096);
        if (addr_q.size() > 0)
            check("t5_last_addr", 64'(addr_q[addr_q.size() - 1]), 64'd4095);
        check("t5_addr_seq", 64'(cmp_q(addr_q, gold_a)), 64'd0);
        check("t5_pix_seq", 64'(cmp_q(pix_q, gold_p)), 64'd0);
        check("t5_stall_hold", 64'(stall_viol), 64'd0);
        check("t5_done_cnt", 64'(done_cnt), 64'd1);

        // N=4, M=1 with start re-asserted while busy
        clear_mon();
        start_xfer(4, 0);
        image_size = SIZE_W'(8);
        m_log2     = MLOG_W'(1);
        start      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        check("t6_M_held", 64'(M), 64'd1);
        check("t6_busy", 64'(busy), 64'd1);
        wait_done(0, 200, ok);
        check("t6_done_seen", 64'(ok), 64'd1);
        gold_fill(4, 1);
        check("t6_addr_seq", 64'(cmp_q(addr_q, gold_a)), 64'd0);
        check("t6_pix_seq", 64'(cmp_q(pix_q, gold_p)), 64'd0);
        check("t6_done_cnt", 64'(done_cnt), 64'd1);
        check("t6_busy_after", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
